// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Imported by the loader and by anything that needs to decode its state.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_WORD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes
// little-endian words into instruction memory, holding the CPU in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
    localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_t          state_reg;
    logic [7:0]      cnt_lo_reg;
    logic [15:0]     count_reg;
    logic [CW-1:0]   word_cnt_reg;
    logic [1:0]      lane_reg;
    logic [7:0]      xor_reg;
    // Only three bytes are buffered; byte 3 is taken straight from in_data.
    logic [23:0]     shift_reg;

    logic            accept;
    logic [15:0]     hdr_count;
    logic [15:0]     word_cnt_next;
    logic [31:0]     word_addr;

    assign accept        = in_valid & in_ready;
    assign hdr_count     = {in_data, cnt_lo_reg};
    assign word_cnt_next = 16'(word_cnt_reg) + 16'd1;
    assign word_addr     = BASE_ADDR + 32'({word_cnt_reg, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_CNT_LO;
            cnt_lo_reg   <= 8'd0;
            count_reg    <= 16'd0;
            word_cnt_reg <= '0;
            lane_reg     <= 2'd0;
            xor_reg      <= 8'd0;
            shift_reg    <= 24'd0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wd       <= 32'd0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= (state_reg != S_DONE) && (state_reg != S_ERR);
            if (accept) begin
                xor_reg <= xor_reg ^ in_data;
            end
            case (state_reg)
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_lo_reg <= in_data;
                        state_reg  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count_reg <= hdr_count;
                        if ({1'b0, hdr_count} > DEPTH_W) begin
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                            in_ready  <= 1'b0;
                        end else if (hdr_count == 16'd0) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    if (accept) begin
                        lane_reg  <= lane_reg + 2'd1;
                        shift_reg <= {in_data, shift_reg[23:8]};
                        if (lane_reg == LAST_LANE) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_addr;
                            mem_wd       <= {in_data, shift_reg};
                            word_cnt_reg <= word_cnt_reg + CW'(1);
                            if (word_cnt_next == count_reg) begin
                                state_reg <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == xor_reg) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed timing sequences, a vector table
// and randomized images, all checked against a stream-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    int          acc_q[$];
    logic [7:0]  img[$];
    bit          exp_done;
    bit          exp_err;
    int          done_cyc = -1;
    int          err_cyc = -1;
    int          passed = 0;
    int          total = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) got_q.push_back('{mem_addr, mem_wd, cyc});
            if (done && done_cyc < 0) done_cyc = cyc;
            if (error && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference model: interprets the byte image directly from the stream format.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = {img[1], img[0]};
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            int b = HDR_BYTES + BYTES_PER_WORD * i;
            exp_q.push_back('{BASE + 32'(4 * i), {img[b+3], img[b+2], img[b+1], img[b]}, 0});
        end
        x = 8'd0;
        for (int i = 0; i < img.size() - 1; i++) x ^= img[i];
        if (x == img[img.size()-1]) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] x;
        logic [15:0] n16;
        img.delete();
        n16 = 16'(n);
        img.push_back(n16[7:0]);
        img.push_back(n16[15:8]);
        if (n > DEPTH) return;
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom_range(0, 255)));
        x = 8'd0;
        foreach (img[i]) x ^= img[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
        img.push_back(x);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", mem_addr, BASE);
            check("rst_mem_wd", mem_wd, 32'd0);
            check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            check("rst_done", 32'(done), 32'd0);
            check("rst_error", 32'(error), 32'd0);
        end
        reset = 1'b0;
        got_q.delete();
        acc_q.delete();
        done_cyc = -1;
        err_cyc = -1;
    endtask

    // Called at a negedge; each byte is held until in_ready is seen high.
    task automatic send(input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) begin
            int waitn = 0;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = img[i];
            while (!in_ready) begin
                @(negedge clk);
                waitn++;
                if (waitn > 50) begin
                    total++;
                    $display("FAIL ready_timeout: byte %0d never accepted, in_ready=%b required 1", i, in_ready);
                    in_valid = 1'b0;
                    return;
                end
            end
            acc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_case(input string name);
        int m;
        repeat (3) @(negedge clk);
        check({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({name, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({name, "_data"}, got_q[i].data, exp_q[i].data);
        end
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        $display("case %s: bytes=%0d writes=%0d done=%b error=%b cpu_reset=%b",
                 name, img.size(), got_q.size(), done, error, cpu_reset);
    endtask

    typedef struct {
        int n;
        bit bad;
        int gap;
        bit exp_done;
        bit exp_err;
        int exp_nwr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2, 1'b0, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{5, 1'b0, 30, 1'b1, 1'b0, 5};
        vecs[2] = '{4, 1'b1, 0, 1'b0, 1'b1, 4};
        vecs[3] = '{64, 1'b0, 10, 1'b1, 1'b0, 64};
        vecs[4] = '{65, 1'b0, 0, 1'b0, 1'b1, 0};
        vecs[5] = '{1, 1'b1, 50, 1'b0, 1'b1, 1};
        vecs[6] = '{0, 1'b1, 0, 1'b0, 1'b1, 0};

        repeat (2) @(negedge clk);
        do_reset(1'b1);

        // One-word image, back-to-back, with latency checks.
        img = '{8'h01, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'hA1};
        model();
        send(0, 6, 0);
        finish_case("one_word");
        check("one_word_wd_const", got_q.size() > 0 ? got_q[0].data : 32'hX, 32'hE04F000F);
        check("one_word_we_cycle", got_q.size() > 0 ? 32'(got_q[0].c) : 32'hX, 32'(acc_q[5]));
        check("one_word_done_cycle", 32'(done_cyc), 32'(acc_q[6]));

        // Same image, wrong checksum.
        do_reset(1'b1);
        img = '{8'h01, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'hA0};
        model();
        send(0, 6, 0);
        finish_case("bad_csum");
        check("bad_csum_err_cycle", 32'(err_cyc), 32'(acc_q[6]));

        // Oversize count.
        do_reset(1'b1);
        img = '{8'h41, 8'h00};
        model();
        send(0, 1, 0);
        finish_case("oversize");
        check("oversize_err_cycle", 32'(err_cyc), 32'(acc_q[1]));

        // Empty image.
        do_reset(1'b1);
        img = '{8'h00, 8'h00, 8'h00};
        model();
        send(0, 2, 0);
        finish_case("empty");

        // Three words, back-to-back: one write every four cycles.
        do_reset(1'b1);
        build(3, 1'b0);
        model();
        send(0, img.size() - 1, 0);
        finish_case("three_b2b");
        if (got_q.size() == 3) begin
            check("three_b2b_spacing1", 32'(got_q[1].c - got_q[0].c), 32'd4);
            check("three_b2b_spacing2", 32'(got_q[2].c - got_q[1].c), 32'd4);
        end

        // Three words with random valid gaps.
        do_reset(1'b1);
        build(3, 1'b0);
        model();
        send(0, img.size() - 1, 40);
        finish_case("three_gaps");

        // Reset after two bytes of the first word, then a full reload.
        do_reset(1'b1);
        build(3, 1'b0);
        send(0, 3, 0);
        do_reset(1'b1);
        check("midrst_no_write", 32'(got_q.size()), 32'd0);
        build(3, 1'b0);
        model();
        send(0, img.size() - 1, 20);
        finish_case("mid_reset_reload");

        // Vector table.
        foreach (vecs[v]) begin
            do_reset(1'b1);
            build(vecs[v].n, vecs[v].bad);
            model();
            check("vec_model_done", 32'(exp_done), 32'(vecs[v].exp_done));
            send(0, img.size() - 1, vecs[v].gap);
            finish_case($sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_nwr", v), 32'(got_q.size()), 32'(vecs[v].exp_nwr));
            check($sformatf("vec%0d_tbl_done", v), 32'(done), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_tbl_err", v), 32'(error), 32'(vecs[v].exp_err));
        end

        // Randomized images.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 300) : $urandom_range(0, 8);
            do_reset(1'b1);
            build(n, $urandom_range(0, 2) == 0);
            model();
            send(0, img.size() - 1, $urandom_range(0, 50));
            finish_case($sformatf("rand%0d", r));
        end

        do_reset(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
